// File: rtl/sd_data_rx.sv
// SD card data-line block receiver: waits for the start bit, deserialises one block
// into 32-bit words on 1 or 4 lanes, checks the per-lane CRC16 and the stop bit.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for start_i, configuration latched on acceptance
// WAIT_START | looking for the start bit, optional timeout down-counter runs
// DATA       | shifting data samples into words, per-lane CRC accumulates
// CRC        | 16 cycles collecting the received CRC of each used lane
// STOP       | stop-bit check and CRC compare, done_o follows
module sd_data_rx #(
  parameter int BLKSIZE_W = 12,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 bus_4bit_i,
  input  logic [BLKSIZE_W-1:0] blksize_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [3:0]           dat_i,
  input  logic                 full_i,
  output logic                 wr_o,
  output logic [31:0]          dat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 crc_err_o,
  output logic                 timeout_o,
  output logic                 overflow_o
);

  localparam int CNT_W = BLKSIZE_W + 3;
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CRC_LEN_M1 = CNT_W'(15);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE    = TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   bus4_q;
  logic [BLKSIZE_W-1:0]   blksize_q;
  logic                   tmo_en_q;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [4:0]             word_cnt_q;
  logic [31:0]            shift_q;
  logic [3:0][15:0]       crc_q;
  logic [3:0][15:0]       crc_rx_q;

  logic                   done_d, wr_d, tmo_hit, crc_chk;
  logic                   start_seen, cnt_tc, tmo_tc, word_tc;
  logic                   stop_bad, crc_bad;
  logic [3:0]             used;
  logic [31:0]            shift_d;
  logic [CNT_W-1:0]       data_len;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    crc16_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign used       = bus4_q ? 4'hf : 4'h1;
  assign start_seen = bus4_q ? (dat_i == 4'h0) : ~dat_i[0];
  assign cnt_tc     = (cnt_q == '0);
  assign tmo_tc     = tmo_en_q && (tmo_cnt_q == TMO_ONE);
  assign word_tc    = (word_cnt_q == 5'd0);
  assign stop_bad   = |(~dat_i & used);
  assign shift_d    = bus4_q ? {shift_q[27:0], dat_i} : {shift_q[30:0], dat_i[0]};
  assign data_len   = bus4_q ? {2'b00, blksize_q, 1'b0} : {blksize_q, 3'b000};
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    crc_bad = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (used[l] && (crc_q[l] != crc_rx_q[l])) crc_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    wr_d    = 1'b0;
    tmo_hit = 1'b0;
    crc_chk = 1'b0;
    if ((state_q != IDLE) && abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (start_i) state_d = WAIT_START;
        WAIT_START: begin
          // a start bit arriving on the very last allowed cycle still wins
          if (start_seen) begin
            state_d = DATA;
          end else if (tmo_tc) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tmo_hit = 1'b1;
          end
        end
        DATA: begin
          wr_d = word_tc;
          if (cnt_tc) state_d = CRC;
        end
        CRC:  if (cnt_tc) state_d = STOP;
        STOP: begin
          state_d = IDLE;
          done_d  = 1'b1;
          crc_chk = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_o       <= 1'b0;
      dat_o      <= '0;
      done_o     <= 1'b0;
      crc_err_o  <= 1'b0;
      timeout_o  <= 1'b0;
      overflow_o <= 1'b0;
      bus4_q     <= 1'b0;
      blksize_q  <= '0;
      tmo_en_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      crc_q      <= '0;
      crc_rx_q   <= '0;
    end else begin
      state_q <= state_d;
      done_o  <= done_d;
      wr_o    <= wr_d;
      if (wr_o && full_i) overflow_o <= 1'b1;
      if (tmo_hit) timeout_o <= 1'b1;
      if (crc_chk && (stop_bad || crc_bad)) crc_err_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            bus4_q     <= bus_4bit_i;
            blksize_q  <= blksize_i;
            tmo_en_q   <= |timeout_i;
            tmo_cnt_q  <= timeout_i;
            word_cnt_q <= bus_4bit_i ? 5'd7 : 5'd31;
            shift_q    <= '0;
            crc_q      <= '0;
            crc_rx_q   <= '0;
            crc_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
            overflow_o <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!abort_i) begin
            if (start_seen) cnt_q <= data_len - CNT_ONE;
            else            tmo_cnt_q <= tmo_cnt_q - TMO_ONE;
          end
        end
        DATA: begin
          if (!abort_i) begin
            shift_q <= shift_d;
            for (int l = 0; l < 4; l++) begin
              if (used[l]) crc_q[l] <= crc16_step(crc_q[l], dat_i[l]);
            end
            if (word_tc) begin
              dat_o      <= shift_d;
              word_cnt_q <= bus4_q ? 5'd7 : 5'd31;
            end else begin
              word_cnt_q <= word_cnt_q - 5'd1;
            end
            cnt_q <= cnt_tc ? CRC_LEN_M1 : cnt_q - CNT_ONE;
          end
        end
        CRC: begin
          if (!abort_i) begin
            for (int l = 0; l < 4; l++) begin
              crc_rx_q[l] <= {crc_rx_q[l][14:0], dat_i[l]};
            end
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
